// File: rtl/aqed_seq_pkg.sv
// Shared types and helpers for the A-QED instruction-sequence decoder.
// Optional formal constraints are enabled in the top by defining AQED_SEQ_ASSUME_EN.
package aqed_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    // Predecessor index that stands for "nothing issued yet".
    function automatic int no_pred_idx(input int num_instr);
        return num_instr;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int k = 0; k < 32; k++) begin
            n = n + 6'(v[k]);
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) idx = 5'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/aqed_seq_hist.sv
// Shift register of issued decode vectors; slice 0 is the most recent issue.
module aqed_seq_hist #(
    parameter int NUM_INSTR  = 2,
    parameter int HIST_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            shift_en,
    input  logic [NUM_INSTR-1:0]            din,
    output logic [NUM_INSTR*HIST_DEPTH-1:0] hist,
    output logic [HIST_DEPTH-1:0]           valid
);

    generate
        if (HIST_DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist  <= '0;
                    valid <= '0;
                end else if (shift_en) begin
                    hist  <= din;
                    valid <= 1'b1;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist  <= '0;
                    valid <= '0;
                end else if (shift_en) begin
                    hist  <= {hist[NUM_INSTR*(HIST_DEPTH-1)-1:0], din};
                    valid <= {valid[HIST_DEPTH-2:0], 1'b1};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/aqed_seq_decoder.sv
// A-QED decode monitor: qualifies decode flags with __ISSUE__, keeps history, flags rule violations.
// Define AQED_SEQ_ASSUME_EN to emit assume properties that constrain the flags to 0 under formal.
module aqed_seq_decoder
    import aqed_seq_pkg::*;
#(
    parameter int NUM_INSTR  = 2,
    parameter int HIST_DEPTH = 2,
    parameter int CNT_W      = 16,
    parameter logic [NUM_INSTR*(NUM_INSTR+1)-1:0] LEGAL_PRED = '1
) (
    input  logic                            __DECODER_CLOCK__,
    input  logic                            __DECODER_RESET_N__,
    input  logic                            __ISSUE__,
    input  logic [NUM_INSTR-1:0]            decode_in,
    output logic [NUM_INSTR-1:0]            decode_d,
    output logic [NUM_INSTR*HIST_DEPTH-1:0] hist_out,
    output logic [HIST_DEPTH-1:0]           hist_valid,
    output logic [CNT_W-1:0]                issue_cnt,
    output logic                            viol_none,
    output logic                            viol_multi,
    output logic                            viol_seq,
    output logic                            err_sticky,
    output logic [1:0]                      state_o
);

    localparam int NO_PRED = no_pred_idx(NUM_INSTR);

    logic [1:0]                           state_q;
    logic [1:0]                           state_d;
    logic [5:0]                           pc;
    int                                   pred_j;
    int                                   sel;
    logic [NUM_INSTR*(NUM_INSTR+1)-1:0]   legal_sh;
    logic                                 viol_any;

    aqed_seq_hist #(
        .NUM_INSTR (NUM_INSTR),
        .HIST_DEPTH(HIST_DEPTH)
    ) u_hist (
        .clk     (__DECODER_CLOCK__),
        .rst_n   (__DECODER_RESET_N__),
        .shift_en(__ISSUE__),
        .din     (decode_in),
        .hist    (hist_out),
        .valid   (hist_valid)
    );

    // Predecessor is "none" until a real issue sits in slice 0.
    always_comb begin
        pc     = popcount(32'(decode_in));
        pred_j = NO_PRED;
        if (state_q != ST_IDLE && hist_valid[0]) begin
            pred_j = int'({27'd0, onehot_to_idx(32'(hist_out[NUM_INSTR-1:0]))});
        end
        sel        = int'({27'd0, onehot_to_idx(32'(decode_in))}) * (NUM_INSTR + 1) + pred_j;
        legal_sh   = LEGAL_PRED >> sel;
        viol_none  = __ISSUE__ && (pc == 6'd0);
        viol_multi = __ISSUE__ && (pc > 6'd1);
        viol_seq   = __ISSUE__ && (pc == 6'd1) && !legal_sh[0];
        viol_any   = viol_none || viol_multi || viol_seq;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (__ISSUE__) state_d = viol_any ? ST_ERROR : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (viol_any) state_d = ST_ERROR;
            end
            default: state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge __DECODER_CLOCK__ or negedge __DECODER_RESET_N__) begin
        if (!__DECODER_RESET_N__) begin
            state_q    <= ST_IDLE;
            decode_d   <= '0;
            issue_cnt  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_sticky <= err_sticky | viol_any;
            if (__ISSUE__) begin
                decode_d <= decode_in;
                if (issue_cnt != {CNT_W{1'b1}}) issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    // The unused encoding reports as ERROR.
    assign state_o = (state_q == 2'd3) ? ST_ERROR : state_q;

`ifdef AQED_SEQ_ASSUME_EN
    a_one_at_a_time: assume property (@(posedge __DECODER_CLOCK__) disable iff (!__DECODER_RESET_N__)
        !__ISSUE__ || (pc <= 6'd1));
    a_any_valid: assume property (@(posedge __DECODER_CLOCK__) disable iff (!__DECODER_RESET_N__)
        !__ISSUE__ || (pc != 6'd0));
    a_pred_legal: assume property (@(posedge __DECODER_CLOCK__) disable iff (!__DECODER_RESET_N__)
        !__ISSUE__ || (pc != 6'd1) || legal_sh[0]);
`else
`endif

endmodule

// File: tb/tb_aqed_seq_decoder.sv
// Directed and randomized checks of aqed_seq_decoder against a queue-based issue-history model.
module tb_aqed_seq_decoder;

    localparam int NI = 2;
    localparam int HD = 2;
    localparam int CW = 2;
    // instr0 may not follow instr1 (bit 1), instr1 may not issue first (bit 5)
    localparam logic [5:0] LEGAL = 6'b011101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue;
    logic [NI-1:0] dec;
    logic [NI-1:0] decode_d;
    logic [NI*HD-1:0] hist_out;
    logic [HD-1:0] hist_valid;
    logic [CW-1:0] issue_cnt;
    logic          viol_none, viol_multi, viol_seq, err_sticky;
    logic [1:0]    state_o;

    int tests = 0;
    int fails = 0;

    logic [1:0] mh[$];
    int         m_cnt;
    bit         m_err;
    logic [5:0] legal = LEGAL;

    aqed_seq_decoder #(
        .NUM_INSTR (NI),
        .HIST_DEPTH(HD),
        .CNT_W     (CW),
        .LEGAL_PRED(LEGAL)
    ) dut (
        .__DECODER_CLOCK__  (clk),
        .__DECODER_RESET_N__(rst_n),
        .__ISSUE__          (issue),
        .decode_in          (dec),
        .decode_d           (decode_d),
        .hist_out           (hist_out),
        .hist_valid         (hist_valid),
        .issue_cnt          (issue_cnt),
        .viol_none          (viol_none),
        .viol_multi         (viol_multi),
        .viol_seq           (viol_seq),
        .err_sticky         (err_sticky),
        .state_o            (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [1:0] s0, s1;
        int         sz;
        sz = mh.size();
        s0 = (sz > 0) ? mh[0] : 2'b00;
        s1 = (sz > 1) ? mh[1] : 2'b00;
        chk({tag, ".decode_d"},   32'(decode_d),   32'(s0));
        chk({tag, ".hist_out"},   32'(hist_out),   32'({s1, s0}));
        chk({tag, ".hist_valid"}, 32'(hist_valid), (sz > 1) ? 32'd3 : 32'(sz));
        chk({tag, ".issue_cnt"},  32'(issue_cnt),  32'(m_cnt));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
        chk({tag, ".state"},      32'(state_o),    m_err ? 32'd2 : (sz > 0 ? 32'd1 : 32'd0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".decode_d"},   32'(decode_d),   32'd0);
        chk({tag, ".hist_out"},   32'(hist_out),   32'd0);
        chk({tag, ".hist_valid"}, 32'(hist_valid), 32'd0);
        chk({tag, ".issue_cnt"},  32'(issue_cnt),  32'd0);
        chk({tag, ".flags"},      32'({viol_none, viol_multi, viol_seq}), 32'd0);
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'd0);
        chk({tag, ".state"},      32'(state_o),    32'd0);
    endtask

    // Drive one cycle; check flags combinationally, then registered state after the edge.
    task automatic step(input string tag, input logic iss, input logic [1:0] v);
        int  pc, i, j;
        bit  e_none, e_multi, e_seq, seq_known;
        @(negedge clk);
        issue = iss;
        dec   = v;
        #1;
        pc        = $countones(v);
        e_none    = iss && (pc == 0);
        e_multi   = iss && (pc > 1);
        e_seq     = 1'b0;
        seq_known = 1'b1;
        if (iss && pc == 1) begin
            i = v[1] ? 1 : 0;
            if (mh.size() == 0) j = NI;
            else if ($countones(mh[0]) == 1) j = mh[0][1] ? 1 : 0;
            else seq_known = 1'b0;
            if (seq_known) e_seq = !legal[i*(NI+1)+j];
        end
        chk({tag, ".viol_none"},  32'(viol_none),  32'(e_none));
        chk({tag, ".viol_multi"}, 32'(viol_multi), 32'(e_multi));
        if (seq_known) chk({tag, ".viol_seq"}, 32'(viol_seq), 32'(e_seq));
        @(posedge clk);
        if (iss) begin
            mh.push_front(v);
            if (mh.size() > HD) void'(mh.pop_back());
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (e_none || e_multi || e_seq) m_err = 1'b1;
        end
        #1;
        check_regs(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next clock.
    task automatic rst_mid(input string tag);
        @(negedge clk);
        #2;
        issue = 1'b0;
        dec   = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        mh.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic    iss;
        logic [1:0] v;
        int      r;
        rst_n = 1'b0;
        issue = 1'b0;
        dec   = '0;
        mh.delete();
        m_cnt = 0;
        m_err = 1'b0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        step("first_01", 1'b1, 2'b01);
        step("multi_11", 1'b1, 2'b11);
        step("none_00", 1'b1, 2'b00);
        step("idle_hold", 1'b0, 2'b00);
        rst_mid("reset_in_error");

        step("illegal_first_10", 1'b1, 2'b10);
        rst_mid("reset2");
        step("seq_01", 1'b1, 2'b01);
        step("seq_10_after_01", 1'b1, 2'b10);
        step("seq_01_after_10", 1'b1, 2'b01);
        rst_mid("reset3");

        step("sat1", 1'b1, 2'b01);
        step("sat2", 1'b1, 2'b01);
        step("gap", 1'b0, 2'b10);
        step("sat3", 1'b1, 2'b10);
        step("sat4", 1'b1, 2'b10);
        step("sat5", 1'b1, 2'b10);
        rst_mid("reset4");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) rst_mid("rand_reset");
            iss = ($urandom_range(0, 4) != 0);
            r   = $urandom_range(0, 9);
            v   = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            step("rand", iss, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
